// File: rtl/user_tlp_req_arbiter_if.sv
// Bundles the requester-side request bus, the TLP encoder controller bus and
// the completion-side tag lookup of user_tlp_req_arbiter.
//   slave  : the arbiter (consumes requests and completion beats, drives the encoder)
//   master : requesters, encoder and completion decoder
//   req_*  : per-requester request bus, packed NUM_REQ slices
//   tx_*   : encoder controller bus
//   cpl_*  : completion tag lookup and tag release
//   tags_outstanding : number of allocated read tags
interface user_tlp_req_arbiter_if #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_COUNT = 32,
    parameter int unsigned REQ_ID_W  = 3
);
    localparam int unsigned CNT_W = $clog2(TAG_COUNT) + 1;

    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [3*NUM_REQ-1:0]     req_type;
    logic [64*NUM_REQ-1:0]    req_addr;
    logic [128*NUM_REQ-1:0]   req_data;
    logic [11*NUM_REQ-1:0]    req_length;
    logic [7:0]               req_tag;
    logic [NUM_REQ-1:0]       req_err;

    logic [2:0]               tx_type;
    logic [7:0]               tx_tag;
    logic [63:0]              tx_addr;
    logic [127:0]             tx_data;
    logic [10:0]              tx_length;
    logic                     tx_start;
    logic                     tx_done;

    logic                     cpl_valid;
    logic [7:0]               cpl_tag;
    logic                     cpl_last;
    logic [REQ_ID_W-1:0]      cpl_req_id;
    logic                     cpl_req_id_valid;
    logic                     cpl_tag_err;
    logic [CNT_W-1:0]         tags_outstanding;

    modport slave (
        input  req_valid, req_type, req_addr, req_data, req_length,
        output req_ready, req_tag, req_err,
        output tx_type, tx_tag, tx_addr, tx_data, tx_length, tx_start,
        input  tx_done,
        input  cpl_valid, cpl_tag, cpl_last,
        output cpl_req_id, cpl_req_id_valid, cpl_tag_err, tags_outstanding
    );

    modport master (
        output req_valid, req_type, req_addr, req_data, req_length,
        input  req_ready, req_tag, req_err,
        input  tx_type, tx_tag, tx_addr, tx_data, tx_length, tx_start,
        output tx_done,
        output cpl_valid, cpl_tag, cpl_last,
        input  cpl_req_id, cpl_req_id_valid, cpl_tag_err, tags_outstanding
    );
endinterface

// File: rtl/user_tlp_req_arbiter.sv
// Round-robin arbiter sharing the user TLP encoder between NUM_REQ requesters.
// Owns the read tag pool: allocates the lowest free tag per MemRd, frees it on
// the last completion, and reports the owning requester of each completion.
// Ports:
//   user_clk : clock
//   reset_n  : asynchronous active-low reset
//   bus      : user_tlp_req_arbiter_if.slave (request, encoder and completion buses)
module user_tlp_req_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned TAG_COUNT = 32,
    parameter int unsigned REQ_ID_W  = 3
) (
    input  logic                  user_clk,
    input  logic                  reset_n,
    user_tlp_req_arbiter_if.slave bus
);
    localparam int unsigned TAG_IDX_W = $clog2(TAG_COUNT);
    localparam int unsigned CNT_W     = TAG_IDX_W + 1;
    localparam logic [REQ_ID_W-1:0] RR_RESET = REQ_ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

    state_t                state_q, state_d;

    logic [NUM_REQ-1:0]    req_illegal, eligible;
    logic [REQ_ID_W-1:0]   rr_ptr_q, pick_idx;
    logic                  pick_found, pick_illegal;
    logic [2:0]            pick_type;
    int unsigned           cand;

    logic [TAG_COUNT-1:0]  tag_alloc_q;
    logic [REQ_ID_W-1:0]   owner_q [TAG_COUNT];
    logic [CNT_W-1:0]      tag_cnt_q;
    logic [TAG_IDX_W-1:0]  free_idx;
    logic                  free_found;

    logic [TAG_IDX_W-1:0]  cpl_idx;
    logic                  cpl_known, cpl_free;

    logic                  arb_en_c, grant_c, grant_err_c, grant_legal_c, grant_read_c;

    logic [NUM_REQ-1:0]    ready_q, err_q;
    logic [7:0]            req_tag_q;
    logic [2:0]            tx_type_q;
    logic [7:0]            tx_tag_q;
    logic [63:0]           tx_addr_q;
    logic [127:0]          tx_data_q;
    logic [10:0]           tx_length_q;
    logic                  tx_start_q;
    logic [REQ_ID_W-1:0]   cpl_req_id_q;
    logic                  cpl_id_valid_q, cpl_tag_err_q;

    // Lowest-index free tag.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned t = 0; t < TAG_COUNT; t++) begin
            if (!free_found && !tag_alloc_q[t]) begin
                free_found = 1'b1;
                free_idx   = TAG_IDX_W'(t);
            end
        end
    end

    // Request classification; a requester whose accept pulse is still high is
    // masked so an illegal request is not consumed twice.
    always_comb begin
        req_illegal = '0;
        eligible    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_illegal[i] = (bus.req_length[i*11 +: 11] == 11'd0) ||
                             bus.req_type[i*3 + 2] ||
                             (bus.req_type[i*3] && (bus.req_length[i*11 +: 11] > 11'd4));
            eligible[i]    = bus.req_valid[i] && !ready_q[i] &&
                             (req_illegal[i] || bus.req_type[i*3] || free_found);
        end
    end

    // Round-robin pick: first eligible requester after rr_ptr_q.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(rr_ptr_q) + k) % NUM_REQ;
            if (!pick_found && eligible[cand]) begin
                pick_found = 1'b1;
                pick_idx   = REQ_ID_W'(cand);
            end
        end
        pick_illegal = req_illegal[pick_idx];
        pick_type    = bus.req_type[32'(pick_idx)*3 +: 3];
    end

    // FSM state register.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pick_found && !pick_illegal) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.tx_done) state_d = (pick_found && !pick_illegal) ? S_START : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs. Arbitration also runs in the tx_done cycle so the next
    // tx_start lands two cycles after tx_done.
    always_comb begin
        arb_en_c      = (state_q == S_IDLE) || ((state_q == S_WAIT) && bus.tx_done);
        grant_c       = arb_en_c && pick_found;
        grant_err_c   = grant_c && pick_illegal;
        grant_legal_c = grant_c && !pick_illegal;
        grant_read_c  = grant_legal_c && !pick_type[0];
    end

    // Grant handshake and encoder command registers.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= RR_RESET;
            ready_q     <= '0;
            err_q       <= '0;
            req_tag_q   <= '0;
            tx_type_q   <= '0;
            tx_tag_q    <= '0;
            tx_addr_q   <= '0;
            tx_data_q   <= '0;
            tx_length_q <= '0;
            tx_start_q  <= 1'b0;
        end else begin
            ready_q    <= '0;
            err_q      <= '0;
            tx_start_q <= (state_q == S_START);
            if (grant_c) begin
                rr_ptr_q  <= pick_idx;
                ready_q   <= NUM_REQ'(1) << pick_idx;
                err_q     <= grant_err_c ? (NUM_REQ'(1) << pick_idx) : '0;
                req_tag_q <= grant_read_c ? 8'(free_idx) : 8'd0;
            end
            if (grant_legal_c) begin
                tx_type_q   <= pick_type;
                tx_tag_q    <= grant_read_c ? 8'(free_idx) : 8'd0;
                tx_addr_q   <= bus.req_addr[32'(pick_idx)*64 +: 64];
                tx_data_q   <= bus.req_data[32'(pick_idx)*128 +: 128];
                tx_length_q <= bus.req_length[32'(pick_idx)*11 +: 11];
            end
        end
    end

    // Completion tag classification against the pre-update pool.
    always_comb begin
        cpl_idx   = bus.cpl_tag[TAG_IDX_W-1:0];
        cpl_known = (32'(bus.cpl_tag) < TAG_COUNT) && tag_alloc_q[cpl_idx];
        cpl_free  = bus.cpl_valid && bus.cpl_last && cpl_known;
    end

    // Tag pool; allocate and free never target the same tag in one cycle.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_alloc_q <= '0;
            tag_cnt_q   <= '0;
            for (int unsigned t = 0; t < TAG_COUNT; t++) begin
                owner_q[t] <= '0;
            end
        end else begin
            if (grant_read_c) begin
                tag_alloc_q[free_idx] <= 1'b1;
                owner_q[free_idx]     <= pick_idx;
            end
            if (cpl_free) begin
                tag_alloc_q[cpl_idx] <= 1'b0;
            end
            tag_cnt_q <= tag_cnt_q + CNT_W'(grant_read_c) - CNT_W'(cpl_free);
        end
    end

    // Registered owner lookup for the completion path.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            cpl_req_id_q   <= '0;
            cpl_id_valid_q <= 1'b0;
            cpl_tag_err_q  <= 1'b0;
        end else begin
            cpl_id_valid_q <= bus.cpl_valid && cpl_known;
            cpl_tag_err_q  <= bus.cpl_valid && !cpl_known;
            cpl_req_id_q   <= (bus.cpl_valid && cpl_known) ? owner_q[cpl_idx] : '0;
        end
    end

    assign bus.req_ready        = ready_q;
    assign bus.req_err          = err_q;
    assign bus.req_tag          = req_tag_q;
    assign bus.tx_type          = tx_type_q;
    assign bus.tx_tag           = tx_tag_q;
    assign bus.tx_addr          = tx_addr_q;
    assign bus.tx_data          = tx_data_q;
    assign bus.tx_length        = tx_length_q;
    assign bus.tx_start         = tx_start_q;
    assign bus.cpl_req_id       = cpl_req_id_q;
    assign bus.cpl_req_id_valid = cpl_id_valid_q;
    assign bus.cpl_tag_err      = cpl_tag_err_q;
    assign bus.tags_outstanding = tag_cnt_q;
endmodule

// File: tb/tb_user_tlp_req_arbiter.sv
// Scoreboard bench for user_tlp_req_arbiter: stimulus pushes expected grants,
// encoder commands and completion lookups; a negedge monitor pops and compares.
module tb_user_tlp_req_arbiter;
    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned TAG_COUNT = 32;
    localparam int unsigned REQ_ID_W  = 3;

    localparam logic [2:0] MRD32 = 3'b000;
    localparam logic [2:0] MWR32 = 3'b001;
    localparam logic [2:0] MRD64 = 3'b010;

    typedef struct packed {
        logic [3:0] ready;
        logic [3:0] err;
        logic [7:0] tag;
    } grant_t;

    typedef struct packed {
        logic [2:0]   typ;
        logic [7:0]   tag;
        logic [63:0]  addr;
        logic [127:0] data;
        logic [10:0]  len;
    } tx_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] id;
        logic       err;
    } cpl_t;

    logic user_clk = 1'b0;
    logic reset_n  = 1'b1;
    always #5 user_clk = ~user_clk;

    user_tlp_req_arbiter_if #(.NUM_REQ(NUM_REQ), .TAG_COUNT(TAG_COUNT), .REQ_ID_W(REQ_ID_W)) bus ();

    user_tlp_req_arbiter #(.NUM_REQ(NUM_REQ), .TAG_COUNT(TAG_COUNT), .REQ_ID_W(REQ_ID_W)) dut (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .bus      (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int ready_cyc = 0;
    int done_cyc = 0;
    bit have_done = 0;
    bit gap_chk = 0;
    bit enc_hold = 0;

    grant_t gq[$];
    tx_t    tq[$];
    cpl_t   cq[$];
    grant_t mg;
    tx_t    mt;
    cpl_t   mc;

    always @(posedge user_clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    function automatic void exp_grant(int r, logic [7:0] tag, bit err);
        grant_t g;
        g.ready = 4'(1) << r;
        g.err   = err ? (4'(1) << r) : 4'b0;
        g.tag   = tag;
        gq.push_back(g);
    endfunction

    function automatic void exp_tx(logic [2:0] typ, logic [7:0] tag, logic [63:0] addr,
                                   logic [127:0] data, logic [10:0] len);
        tx_t t;
        t.typ = typ; t.tag = tag; t.addr = addr; t.data = data; t.len = len;
        tq.push_back(t);
    endfunction

    function automatic void exp_cpl(bit vld, logic [2:0] id, bit err);
        cpl_t c;
        c.vld = vld; c.id = id; c.err = err;
        cq.push_back(c);
    endfunction

    function automatic logic [127:0] wdata(int r, int n);
        return {32'hC0DE_0000 | 32'(r), 32'(n), 32'hFACE_B00C, 32'(r * 16 + n)};
    endfunction

    // Monitor: compare every DUT output event against the scoreboard queues.
    always @(negedge user_clk) begin
        if (reset_n) begin
            if (bus.req_ready != '0) begin
                if (gq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL grant_unexpected: got req_ready=%b, want none", bus.req_ready);
                end else begin
                    mg = gq.pop_front();
                    chk("grant_ready", 128'(bus.req_ready), 128'(mg.ready));
                    chk("grant_err", 128'(bus.req_err), 128'(mg.err));
                    chk("grant_tag", 128'(bus.req_tag), 128'(mg.tag));
                end
                ready_cyc = cyc;
            end
            if (bus.tx_start) begin
                if (tq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL tx_unexpected: got tx_start with tx_addr=%0h, want none", bus.tx_addr);
                end else begin
                    mt = tq.pop_front();
                    chk("tx_type", 128'(bus.tx_type), 128'(mt.typ));
                    chk("tx_tag", 128'(bus.tx_tag), 128'(mt.tag));
                    chk("tx_addr", 128'(bus.tx_addr), 128'(mt.addr));
                    chk("tx_data", bus.tx_data, mt.data);
                    chk("tx_length", 128'(bus.tx_length), 128'(mt.len));
                    chk("start_after_ready", 128'(cyc), 128'(ready_cyc + 1));
                    if (gap_chk && have_done)
                        chk("start_after_done", 128'(cyc), 128'(done_cyc + 2));
                end
            end
            if (bus.cpl_req_id_valid || bus.cpl_tag_err) begin
                if (cq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL cpl_unexpected: got id_valid=%b err=%b, want none",
                             bus.cpl_req_id_valid, bus.cpl_tag_err);
                end else begin
                    mc = cq.pop_front();
                    chk("cpl_id_valid", 128'(bus.cpl_req_id_valid), 128'(mc.vld));
                    chk("cpl_req_id", 128'(bus.cpl_req_id), 128'(mc.id));
                    chk("cpl_tag_err", 128'(bus.cpl_tag_err), 128'(mc.err));
                end
            end
        end
    end

    // Encoder model: tx_done three cycles after tx_start unless held.
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge user_clk);
            if (bus.tx_start && !enc_hold) begin
                repeat (3) @(negedge user_clk);
                bus.tx_done = 1'b1;
                done_cyc    = cyc;
                have_done   = 1'b1;
                @(negedge user_clk);
                bus.tx_done = 1'b0;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge user_clk);
    endtask

    task automatic issue(input int r, input logic [2:0] typ, input logic [63:0] addr,
                         input logic [127:0] data, input logic [10:0] len);
        bus.req_type[r*3 +: 3]     = typ;
        bus.req_addr[r*64 +: 64]   = addr;
        bus.req_data[r*128 +: 128] = data;
        bus.req_length[r*11 +: 11] = len;
        bus.req_valid[r]           = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge user_clk);
            if (bus.req_ready[r]) begin
                bus.req_valid[r] = 1'b0;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL req%0d_timeout: got no req_ready, want a grant", r);
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic cpl(input logic [7:0] tag, input bit last);
        bus.cpl_tag   = tag;
        bus.cpl_last  = last;
        bus.cpl_valid = 1'b1;
        @(negedge user_clk);
        bus.cpl_valid = 1'b0;
        bus.cpl_last  = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string pfx);
        chk({pfx, "_req_ready"}, 128'(bus.req_ready), 128'd0);
        chk({pfx, "_req_err"}, 128'(bus.req_err), 128'd0);
        chk({pfx, "_req_tag"}, 128'(bus.req_tag), 128'd0);
        chk({pfx, "_tx_start"}, 128'(bus.tx_start), 128'd0);
        chk({pfx, "_tx_type"}, 128'(bus.tx_type), 128'd0);
        chk({pfx, "_tx_tag"}, 128'(bus.tx_tag), 128'd0);
        chk({pfx, "_tx_addr"}, 128'(bus.tx_addr), 128'd0);
        chk({pfx, "_tx_data"}, bus.tx_data, 128'd0);
        chk({pfx, "_tx_length"}, 128'(bus.tx_length), 128'd0);
        chk({pfx, "_cpl_id_valid"}, 128'(bus.cpl_req_id_valid), 128'd0);
        chk({pfx, "_cpl_tag_err"}, 128'(bus.cpl_tag_err), 128'd0);
        chk({pfx, "_tags"}, 128'(bus.tags_outstanding), 128'd0);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        enc_hold       = 1'b0;
        bus.req_valid  = '0;
        bus.cpl_valid  = 1'b0;
        bus.cpl_last   = 1'b0;
        bus.cpl_tag    = '0;
        repeat (2) @(negedge user_clk);
        chk_outputs_zero("rst");
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want completion within budget");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = '0;
        bus.req_type   = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_length = '0;
        bus.cpl_valid  = 1'b0;
        bus.cpl_tag    = '0;
        bus.cpl_last   = 1'b0;
        #1;
        do_reset();

        // Single MemRd64 after reset gets tag 0.
        exp_grant(0, 8'd0, 0);
        exp_tx(MRD64, 8'd0, 64'h0000_0001_0000_1000, 128'd0, 11'd16);
        issue(0, MRD64, 64'h0000_0001_0000_1000, 128'd0, 11'd16);
        cycles(6);
        chk("t1_tags", 128'(bus.tags_outstanding), 128'd1);

        // Four continuous writers: grants 0,1,2,3,0, start two cycles after done.
        do_reset();
        have_done = 1'b0;
        gap_chk   = 1'b1;
        exp_grant(0, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h100, wdata(0, 0), 11'd4);
        exp_grant(1, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h200, wdata(1, 0), 11'd4);
        exp_grant(2, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h300, wdata(2, 0), 11'd4);
        exp_grant(3, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h400, wdata(3, 0), 11'd4);
        exp_grant(0, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h180, wdata(0, 1), 11'd4);
        fork
            begin
                issue(0, MWR32, 64'h100, wdata(0, 0), 11'd4);
                issue(0, MWR32, 64'h180, wdata(0, 1), 11'd4);
            end
            issue(1, MWR32, 64'h200, wdata(1, 0), 11'd4);
            issue(2, MWR32, 64'h300, wdata(2, 0), 11'd4);
            issue(3, MWR32, 64'h400, wdata(3, 0), 11'd4);
        join
        cycles(8);
        gap_chk = 1'b0;
        chk("t2_tags", 128'(bus.tags_outstanding), 128'd0);

        // Fill the pool; tag k is owned by requester (k+3)%4.
        for (int k = 0; k < 32; k++) begin
            exp_grant((k + 3) % 4, 8'(k), 0);
            exp_tx(MRD32, 8'(k), 64'h1000 + 64'(k * 64), 128'd0, 11'd1);
            issue((k + 3) % 4, MRD32, 64'h1000 + 64'(k * 64), 128'd0, 11'd1);
        end
        cycles(6);
        chk("t3_tags_full", 128'(bus.tags_outstanding), 128'd32);

        // Pool full: write bypasses the stalled read; freeing tag 5 releases it.
        exp_grant(2, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h2000, wdata(2, 7), 11'd4);
        exp_cpl(1, 3'd0, 0);
        exp_grant(1, 8'd5, 0); exp_tx(MRD64, 8'd5, 64'h3_0000_0040, 128'd0, 11'd8);
        fork
            issue(2, MWR32, 64'h2000, wdata(2, 7), 11'd4);
            issue(1, MRD64, 64'h3_0000_0040, 128'd0, 11'd8);
            begin
                cycles(12);
                chk("t3_tags_stalled", 128'(bus.tags_outstanding), 128'd32);
                cpl(8'd5, 1);
            end
        join
        cycles(6);
        chk("t3_tags_realloc", 128'(bus.tags_outstanding), 128'd32);

        // Partial then final completion of tag 3 (owner 2).
        exp_cpl(1, 3'd2, 0);
        cpl(8'd3, 0);
        chk("t4_tags_partial", 128'(bus.tags_outstanding), 128'd32);
        exp_cpl(1, 3'd2, 0);
        cpl(8'd3, 1);
        chk("t4_tags_freed", 128'(bus.tags_outstanding), 128'd31);
        exp_cpl(1, 3'd2, 0);
        cpl(8'd31, 0);
        exp_cpl(1, 3'd3, 0);
        cpl(8'd0, 0);
        exp_cpl(1, 3'd1, 0);
        cpl(8'd5, 0);
        cycles(1);

        // Illegal requests and bad completion tags.
        exp_grant(3, 8'd0, 1);
        issue(3, MWR32, 64'h5000, wdata(3, 5), 11'd5);
        exp_grant(0, 8'd0, 1);
        issue(0, MRD32, 64'h5100, 128'd0, 11'd0);
        exp_grant(1, 8'd0, 1);
        issue(1, 3'b100, 64'h5200, wdata(1, 5), 11'd4);
        exp_cpl(0, 3'd0, 1);
        cpl(8'd40, 1);
        exp_cpl(0, 3'd0, 1);
        cpl(8'd3, 1);
        exp_cpl(0, 3'd0, 1);
        cpl(8'd32, 0);
        cycles(4);
        chk("t5_tags", 128'(bus.tags_outstanding), 128'd31);

        // Reset while waiting on the encoder with three tags outstanding.
        do_reset();
        exp_grant(0, 8'd0, 0); exp_tx(MRD32, 8'd0, 64'h6000, 128'd0, 11'd2);
        issue(0, MRD32, 64'h6000, 128'd0, 11'd2);
        exp_grant(1, 8'd1, 0); exp_tx(MRD32, 8'd1, 64'h6100, 128'd0, 11'd2);
        issue(1, MRD32, 64'h6100, 128'd0, 11'd2);
        exp_grant(2, 8'd2, 0); exp_tx(MRD32, 8'd2, 64'h6200, 128'd0, 11'd2);
        issue(2, MRD32, 64'h6200, 128'd0, 11'd2);
        enc_hold = 1'b1;
        cycles(3);
        chk("t6_tags_before", 128'(bus.tags_outstanding), 128'd3);
        #2 reset_n = 1'b0;
        #1 chk_outputs_zero("t6_async");
        @(negedge user_clk);
        reset_n  = 1'b1;
        enc_hold = 1'b0;
        chk("t6_tags_after", 128'(bus.tags_outstanding), 128'd0);
        exp_grant(0, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h7000, wdata(0, 9), 11'd2);
        exp_grant(2, 8'd0, 0); exp_tx(MWR32, 8'd0, 64'h7200, wdata(2, 9), 11'd3);
        fork
            issue(2, MWR32, 64'h7200, wdata(2, 9), 11'd3);
            issue(0, MWR32, 64'h7000, wdata(0, 9), 11'd2);
        join
        cycles(8);

        chk("queues_drained", 128'(gq.size() + tq.size() + cq.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
